alu_issue_unit: RTL and testbench
=================================

// Module: alu_issue_unit
// PURPOSE
//  Front end that drives the ALU: accepts an RV32I OP (R-type) or OP-IMM (I-type) instruction with
//  its rs1/rs2 values, decodes it, and registers in1/in2/func3/func7 onto the ALU inputs.
//  Captures the combinational ALU result and flags one cycle later and returns them with rd.
//  Sits between the decode/register-read stage and writeback; valid/ready on both sides, one op per cycle.
// PARAMETERS
//  XLEN      32  datapath width (only 32 supported)
//  RD_W      5   destination register index width
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  req_valid    in   1     request present
//  req_ready    out  1     unit can accept request this cycle
//  req_instr    in   32    raw instruction word
//  req_rs1      in   XLEN  rs1 value
//  req_rs2      in   XLEN  rs2 value (ignored for OP-IMM)
//  alu_in1      out  XLEN  to ALU in1
//  alu_in2      out  XLEN  to ALU in2
//  alu_func3    out  4     to ALU func3 = {1'b0, funct3}
//  alu_func7    out  4     to ALU func7 = {3'b0, alt}; alt = SUB/SRA select
//  alu_c        in   XLEN  ALU result C
//  alu_zero     in   1     ALU zero flag
//  alu_cout     in   1     ALU carry out
//  alu_ovf      in   1     ALU overflow
//  alu_sign     in   1     ALU sign
//  rsp_valid    out  1     response present
//  rsp_ready    in   1     consumer accepts response
//  rsp_result   out  XLEN  registered ALU result (0 when rsp_illegal)
//  rsp_flags    out  4     {sign, ovf, cout, zero} registered (0 when rsp_illegal)
//  rsp_rd       out  RD_W  destination index
//  rsp_illegal  out  1     instruction not an ALU op or illegal encoding
// BEHAVIOUR
//  - Reset (async, rst_n=0): every output 0, both stage valids 0; req_ready returns to 1 on first cycle after release.
//  - Stage E (issue reg): loads on req_valid&&req_ready; holds alu_* outputs stable while E is valid.
//  - Stage R (response reg): loads from E + alu_* inputs when E valid and (!rsp_valid || rsp_ready).
//  - Latency: request accepted at edge N -> rsp_valid at edge N+1. Throughput 1/cycle with rsp_ready=1.
//  - req_ready = !E_valid || E_advances (combinational pass-through of downstream readiness).
//  - Backpressure: rsp_valid=1, rsp_ready=0 -> R holds, E holds, req_ready=0; nothing dropped or duplicated.
//  - Decode: opcode 0110011 (OP): in2=rs2, alt=funct7[5]; legal iff funct7 in {0000000, 0100000}, and
//    0100000 only with funct3 000 (SUB) or 101 (SRA).
//  - opcode 0010011 (OP-IMM): in2 = sign-extended instr[31:20]; alt=0 except funct3=101 where alt=instr[30].
//    Shifts (001/101): in2 = {27'b0, instr[24:20]}; instr[31:25] must be 0000000 (001) or 0x00/0x20 (101).
//  - Any other opcode or illegal encoding: E loads, alu_in1/in2/func3/func7 driven 0, R captures
//    rsp_illegal=1, result/flags 0, rd still reported.
//  - alu_* outputs driven 0 whenever E is empty.
//  - Arithmetic is entirely the ALU's; this unit does no math beyond immediate sign-extension.
//  - Reset mid-operation: both stages flushed immediately; in-flight ops lost, no response issued.
// STRUCTURE
//  - Shared package rv32_alu_pkg: opcode constants OPC_OP/OPC_OP_IMM, funct3 codes (ADD..AND),
//    FUNCT7_BASE/FUNCT7_ALT, and the 4-bit flag index constants.
//  - One sub-module alu_issue_decode (combinational: instr, rs1, rs2 -> in1, in2, func3, func7, illegal).
//  - Two registered stages in this module; no FSM beyond the two valid bits.
// TESTING
//  - ADD x3,x1,x2 rs1=1 rs2=2, rsp_ready=1 -> one cycle later result 0x00000003, flags 0000, rd=3.
//  - SUB rs1=rs2=0x5 -> result 0, zero=1; alu_func7=4'b0001 while in E.
//  - SLLI shamt=2, rs1=1 -> alu_in2=0x2, result 0x4; SRAI rs1=0x80000000 sh=4 -> 0xF8000000.
//  - ADDI imm=0xFFF rs1=0 -> alu_in2=0xFFFFFFFF, result 0xFFFFFFFF, sign=1.
//  - Back-to-back 4 ops with rsp_ready low 3 cycles mid-stream -> all 4 responses in order, none lost.
//  - Opcode 0000011 and OP funct7=0000001 -> rsp_illegal=1, result 0; rst_n pulse with E,R full -> outputs 0, no response.

Source files
------------

// File: rtl/rv32_alu_pkg.sv
// -----------------------------------------------------------------------------
// rv32_alu_pkg
//  Shared constants for the RV32I ALU issue path: major opcodes, funct3 codes,
//  funct7 encodings and the bit positions inside the 4-bit ALU flag vector.
// -----------------------------------------------------------------------------
package rv32_alu_pkg;

   localparam int XLEN = 32;
   localparam int RD_W = 5;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   typedef enum logic [2:0] {
      F3_ADD  = 3'b000,  // ADD/SUB
      F3_SLL  = 3'b001,
      F3_SLT  = 3'b010,
      F3_SLTU = 3'b011,
      F3_XOR  = 3'b100,
      F3_SR   = 3'b101,  // SRL/SRA
      F3_OR   = 3'b110,
      F3_AND  = 3'b111
   } funct3_e;

   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

   // Bit positions within rsp_flags = {sign, ovf, cout, zero}
   localparam int FLAG_ZERO = 0;
   localparam int FLAG_COUT = 1;
   localparam int FLAG_OVF  = 2;
   localparam int FLAG_SIGN = 3;

endpackage

// File: rtl/alu_issue_decode.sv
// -----------------------------------------------------------------------------
// alu_issue_decode
//  Combinational decode of an RV32I OP / OP-IMM instruction into ALU operands.
//  Ports:
//   instr   in   32    raw instruction word
//   rs1     in   XLEN  rs1 value
//   rs2     in   XLEN  rs2 value (ignored for OP-IMM)
//   in1     out  XLEN  ALU operand 1 (0 when illegal)
//   in2     out  XLEN  ALU operand 2 (rs2, sign-extended imm or shamt; 0 when illegal)
//   func3   out  4     {1'b0, funct3} (0 when illegal)
//   func7   out  4     {3'b0, alt}    (0 when illegal)
//   illegal out  1     not an ALU op, or a reserved encoding
// -----------------------------------------------------------------------------
module alu_issue_decode
   import rv32_alu_pkg::*;
#(
   parameter int XLEN = rv32_alu_pkg::XLEN
) (
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic [XLEN-1:0] in1,
   output logic [XLEN-1:0] in2,
   output logic [3:0]      func3,
   output logic [3:0]      func7,
   output logic            illegal
);

   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] imm_sext;
   logic [XLEN-1:0] shamt;
   logic [XLEN-1:0] op2;
   logic            alt;
   logic            legal;

   // rd and rs1 fields are consumed elsewhere (rd by the top, rs1 as a value).
   logic unused_fields;
   assign unused_fields = &{1'b0, instr[19:15], instr[11:7]};

   assign opcode   = instr[6:0];
   assign f3       = instr[14:12];
   assign f7       = instr[31:25];
   assign imm_sext = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign shamt    = {{(XLEN-5){1'b0}}, instr[24:20]};

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      op2   = '0;
      alt   = 1'b0;
      legal = 1'b0;
      case (opcode)
         OPC_OP: begin
            op2   = rs2;
            alt   = f7[5];
            // The ALT encoding only exists for SUB and SRA.
            legal = (f7 == FUNCT7_BASE) ||
                    ((f7 == FUNCT7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
         end
         OPC_OP_IMM: begin
            legal = 1'b1;
            op2   = imm_sext;
            if (f3 == F3_SLL) begin
               op2   = shamt;
               legal = (f7 == FUNCT7_BASE);
            end else if (f3 == F3_SR) begin
               op2   = shamt;
               alt   = instr[30];
               legal = (f7 == FUNCT7_BASE) || (f7 == FUNCT7_ALT);
            end
         end
         default: legal = 1'b0;
      endcase
   end

   // Illegal ops still flow down the pipe, but with a quiet ALU.
   assign illegal = !legal;
   assign in1     = legal ? rs1 : '0;
   assign in2     = legal ? op2 : '0;
   assign func3   = legal ? {1'b0, f3} : 4'd0;
   assign func7   = legal ? {3'b000, alt} : 4'd0;

endmodule

// File: rtl/alu_issue_unit.sv
// -----------------------------------------------------------------------------
// alu_issue_unit
//  Two-stage front end for the ALU. Stage E registers the decoded operands
//  onto the ALU inputs; stage R captures the ALU result/flags one cycle later
//  and returns them with rd. valid/ready on both sides, one op per cycle.
//  Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_valid/req_ready           request handshake
//   req_instr, req_rs1, req_rs2   instruction word and operand values
//   alu_in1/in2/func3/func7       registered ALU inputs (0 when E is empty)
//   alu_c/zero/cout/ovf/sign      combinational ALU result and flags
//   rsp_valid/rsp_ready           response handshake
//   rsp_result, rsp_flags         result and {sign,ovf,cout,zero} (0 if illegal)
//   rsp_rd, rsp_illegal           destination index, illegal-op marker
// -----------------------------------------------------------------------------
module alu_issue_unit
   import rv32_alu_pkg::*;
#(
   parameter int XLEN = rv32_alu_pkg::XLEN,
   parameter int RD_W = rv32_alu_pkg::RD_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [31:0]     req_instr,
   input  logic [XLEN-1:0] req_rs1,
   input  logic [XLEN-1:0] req_rs2,
   output logic [XLEN-1:0] alu_in1,
   output logic [XLEN-1:0] alu_in2,
   output logic [3:0]      alu_func3,
   output logic [3:0]      alu_func7,
   input  logic [XLEN-1:0] alu_c,
   input  logic            alu_zero,
   input  logic            alu_cout,
   input  logic            alu_ovf,
   input  logic            alu_sign,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_result,
   output logic [3:0]      rsp_flags,
   output logic [RD_W-1:0] rsp_rd,
   output logic            rsp_illegal
);

   logic [XLEN-1:0] dec_in1, dec_in2;
   logic [3:0]      dec_func3, dec_func7;
   logic            dec_illegal;

   alu_issue_decode #(.XLEN(XLEN)) u_decode (
      .instr   (req_instr),
      .rs1     (req_rs1),
      .rs2     (req_rs2),
      .in1     (dec_in1),
      .in2     (dec_in2),
      .func3   (dec_func3),
      .func7   (dec_func7),
      .illegal (dec_illegal)
   );

   // Stage E state
   logic            e_valid;
   logic [XLEN-1:0] e_in1, e_in2;
   logic [3:0]      e_func3, e_func7;
   logic            e_illegal;
   logic [RD_W-1:0] e_rd;

   // Holds req_ready low while in reset and until the first edge after release.
   logic            ready_en;

   logic r_free, e_adv, req_fire;
   logic [3:0] alu_flags;

   assign r_free    = !rsp_valid || rsp_ready;
   assign e_adv     = e_valid && r_free;
   assign req_ready = ready_en && (!e_valid || e_adv);
   assign req_fire  = req_valid && req_ready;

   always_comb begin
      alu_flags            = '0;
      alu_flags[FLAG_ZERO] = alu_zero;
      alu_flags[FLAG_COUT] = alu_cout;
      alu_flags[FLAG_OVF]  = alu_ovf;
      alu_flags[FLAG_SIGN] = alu_sign;
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_en <= 1'b0;
      else        ready_en <= 1'b1;
   end

   // NOTE: the datapath registers are reset as well as the valids, because
   // every output must read 0 during reset, not just the handshake bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_valid   <= 1'b0;
         e_in1     <= '0;
         e_in2     <= '0;
         e_func3   <= '0;
         e_func7   <= '0;
         e_illegal <= 1'b0;
         e_rd      <= '0;
      end else if (req_fire) begin
         e_valid   <= 1'b1;
         e_in1     <= dec_in1;
         e_in2     <= dec_in2;
         e_func3   <= dec_func3;
         e_func7   <= dec_func7;
         e_illegal <= dec_illegal;
         e_rd      <= req_instr[7 +: RD_W];
      end else if (e_adv) begin
         e_valid   <= 1'b0;
      end
   end

   // Operands stay registered; only the valid bit decides whether they show.
   assign alu_in1   = e_valid ? e_in1   : '0;
   assign alu_in2   = e_valid ? e_in2   : '0;
   assign alu_func3 = e_valid ? e_func3 : '0;
   assign alu_func7 = e_valid ? e_func7 : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid   <= 1'b0;
         rsp_result  <= '0;
         rsp_flags   <= '0;
         rsp_rd      <= '0;
         rsp_illegal <= 1'b0;
      end else begin
         if (r_free) rsp_valid <= e_valid;
         if (e_adv) begin
            rsp_result  <= e_illegal ? '0 : alu_c;
            rsp_flags   <= e_illegal ? 4'd0 : alu_flags;
            rsp_rd      <= e_rd;
            rsp_illegal <= e_illegal;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_unit
//  Directed-vector bench for alu_issue_unit. A small behavioural ALU sits on
//  the alu_* ports; expected values are written out by hand per vector.
// -----------------------------------------------------------------------------
module tb_alu_issue_unit;
   import rv32_alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic [31:0] req_instr, req_rs1, req_rs2;
   logic [31:0] alu_in1, alu_in2;
   logic [3:0]  alu_func3, alu_func7;
   logic [31:0] alu_c;
   logic        alu_zero, alu_cout, alu_ovf, alu_sign;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic [4:0]  rsp_rd;
   logic        rsp_illegal;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   alu_issue_unit #(.XLEN(32), .RD_W(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_instr   (req_instr),
      .req_rs1     (req_rs1),
      .req_rs2     (req_rs2),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_func3   (alu_func3),
      .alu_func7   (alu_func7),
      .alu_c       (alu_c),
      .alu_zero    (alu_zero),
      .alu_cout    (alu_cout),
      .alu_ovf     (alu_ovf),
      .alu_sign    (alu_sign),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_flags   (rsp_flags),
      .rsp_rd      (rsp_rd),
      .rsp_illegal (rsp_illegal)
   );

   // Behavioural ALU: cout is carry for ADD, borrow for SUB, 0 otherwise.
   logic [32:0] sum33;
   always_comb begin
      sum33    = '0;
      alu_c    = '0;
      alu_cout = 1'b0;
      alu_ovf  = 1'b0;
      case (alu_func3[2:0])
         3'b000: begin
            if (alu_func7[0]) begin
               alu_c    = alu_in1 - alu_in2;
               alu_cout = (alu_in1 < alu_in2);
               alu_ovf  = (alu_in1[31] != alu_in2[31]) && (alu_c[31] != alu_in1[31]);
            end else begin
               sum33    = {1'b0, alu_in1} + {1'b0, alu_in2};
               alu_c    = sum33[31:0];
               alu_cout = sum33[32];
               alu_ovf  = (alu_in1[31] == alu_in2[31]) && (alu_c[31] != alu_in1[31]);
            end
         end
         3'b001: alu_c = alu_in1 << alu_in2[4:0];
         3'b010: alu_c = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
         3'b011: alu_c = {31'd0, alu_in1 < alu_in2};
         3'b100: alu_c = alu_in1 ^ alu_in2;
         3'b101: alu_c = alu_func7[0] ? 32'($signed(alu_in1) >>> alu_in2[4:0])
                                      : alu_in1 >> alu_in2[4:0];
         3'b110: alu_c = alu_in1 | alu_in2;
         default: alu_c = alu_in1 & alu_in2;
      endcase
      alu_zero = (alu_c == 32'd0);
      alu_sign = alu_c[31];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, OPC_OP};
   endfunction

   function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   // One isolated op: issue, check E contents, then check the response.
   task automatic run_one(input string tag, input logic [31:0] instr,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] e_in1, input logic [31:0] e_in2,
                          input logic [3:0] e_f7, input logic [31:0] e_res,
                          input logic [3:0] e_flags, input logic [4:0] e_rd,
                          input logic e_ill);
      logic [3:0] e_f3;
      e_f3 = e_ill ? 4'd0 : {1'b0, instr[14:12]};
      @(negedge clk);
      req_valid = 1'b1;
      req_instr = instr;
      req_rs1   = rs1;
      req_rs2   = rs2;
      rsp_ready = 1'b1;
      #1 check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      check({tag, "_alu_in1"},   alu_in1, e_in1);
      check({tag, "_alu_in2"},   alu_in2, e_in2);
      check({tag, "_alu_func3"}, {28'd0, alu_func3}, {28'd0, e_f3});
      check({tag, "_alu_func7"}, {28'd0, alu_func7}, {28'd0, e_f7});
      check({tag, "_rsp_early"}, {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, "_result"},    rsp_result, e_res);
      check({tag, "_flags"},     {28'd0, rsp_flags}, {28'd0, e_flags});
      check({tag, "_rd"},        {27'd0, rsp_rd}, {27'd0, e_rd});
      check({tag, "_illegal"},   {31'd0, rsp_illegal}, {31'd0, e_ill});
      check({tag, "_e_empty"},   alu_in1, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int idx;
      int out_idx;
      logic accept;

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_instr = '0;
      req_rs1   = '0;
      req_rs2   = '0;
      rsp_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_req_ready",  {31'd0, req_ready}, 32'd0);
      check("rst_rsp_valid",  {31'd0, rsp_valid}, 32'd0);
      check("rst_alu_in1",    alu_in1, 32'd0);
      check("rst_rsp_result", rsp_result, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

      // Directed single ops
      run_one("add", r_type(FUNCT7_BASE, 5'd2, 5'd1, F3_ADD, 5'd3), 32'd1, 32'd2,
              32'd1, 32'd2, 4'b0000, 32'h0000_0003, 4'b0000, 5'd3, 1'b0);
      run_one("sub", r_type(FUNCT7_ALT, 5'd2, 5'd1, F3_ADD, 5'd4), 32'd5, 32'd5,
              32'd5, 32'd5, 4'b0001, 32'h0000_0000, 4'b0001, 5'd4, 1'b0);
      run_one("slli", i_type({7'b0, 5'd2}, 5'd1, F3_SLL, 5'd5, OPC_OP_IMM), 32'd1, 32'hDEAD_BEEF,
              32'd1, 32'd2, 4'b0000, 32'h0000_0004, 4'b0000, 5'd5, 1'b0);
      run_one("srai", i_type({7'b0100000, 5'd4}, 5'd1, F3_SR, 5'd6, OPC_OP_IMM), 32'h8000_0000, 32'd0,
              32'h8000_0000, 32'd4, 4'b0001, 32'hF800_0000, 4'b1000, 5'd6, 1'b0);
      run_one("addi", i_type(12'hFFF, 5'd1, F3_ADD, 5'd7, OPC_OP_IMM), 32'd0, 32'd0,
              32'd0, 32'hFFFF_FFFF, 4'b0000, 32'hFFFF_FFFF, 4'b1000, 5'd7, 1'b0);
      run_one("ill_load", i_type(12'h004, 5'd1, 3'b010, 5'd8, 7'b0000011), 32'h1234, 32'd9,
              32'd0, 32'd0, 4'b0000, 32'd0, 4'b0000, 5'd8, 1'b1);
      run_one("ill_mul", r_type(7'b0000001, 5'd2, 5'd1, F3_ADD, 5'd9), 32'd6, 32'd7,
              32'd0, 32'd0, 4'b0000, 32'd0, 4'b0000, 5'd9, 1'b1);
      run_one("ill_slli", i_type({7'b0100000, 5'd1}, 5'd1, F3_SLL, 5'd11, OPC_OP_IMM), 32'd3, 32'd0,
              32'd0, 32'd0, 4'b0000, 32'd0, 4'b0000, 5'd11, 1'b1);

      // Back-to-back stream of 4 ADDIs with rsp_ready low for 3 cycles.
      // Op i: rs1 = (i+1)<<8, imm = i+1, rd = 10+i.
      idx     = 0;
      out_idx = 0;
      for (int cyc = 0; cyc < 40 && out_idx < 4; cyc++) begin
         @(negedge clk);
         req_valid = (idx < 4);
         if (idx < 4) begin
            req_instr = i_type(12'(idx + 1), 5'd1, F3_ADD, 5'(10 + idx), OPC_OP_IMM);
            req_rs1   = 32'(idx + 1) << 8;
         end
         rsp_ready = !(cyc inside {2, 3, 4});
         #1;
         accept = req_valid && req_ready;
         if (rsp_valid && !rsp_ready && alu_in1 != 32'd0)
            check("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
         if (rsp_valid && rsp_ready) begin
            check("bp_result", rsp_result, (32'(out_idx + 1) << 8) + 32'(out_idx + 1));
            check("bp_rd", {27'd0, rsp_rd}, 32'(10 + out_idx));
            out_idx++;
         end
         if (accept) idx++;
      end
      check("bp_resp_count", 32'(out_idx), 32'd4);
      @(negedge clk);
      req_valid = 1'b0;
      #1 check("bp_no_dup", {31'd0, rsp_valid}, 32'd0);

      // Reset with both stages full
      @(negedge clk);
      req_valid = 1'b1;
      req_instr = i_type(12'd1, 5'd1, F3_ADD, 5'd14, OPC_OP_IMM);
      req_rs1   = 32'h55;
      rsp_ready = 1'b0;
      @(negedge clk);
      req_instr = r_type(FUNCT7_BASE, 5'd2, 5'd1, F3_ADD, 5'd15);
      req_rs1   = 32'd7;
      req_rs2   = 32'd8;
      @(negedge clk);
      req_valid = 1'b0;
      check("mr_pre_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("mr_pre_alu_in1",   alu_in1, 32'd7);
      #2 rst_n = 1'b0;
      #1;
      check("mr_rsp_valid",  {31'd0, rsp_valid}, 32'd0);
      check("mr_alu_in1",    alu_in1, 32'd0);
      check("mr_rsp_result", rsp_result, 32'd0);
      check("mr_rsp_rd",     {27'd0, rsp_rd}, 32'd0);
      check("mr_req_ready",  {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("mr_no_rsp",   {31'd0, rsp_valid}, 32'd0);
      check("mr_e_empty",  alu_in2, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
